prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter_pkg.sv | 15 +
 rtl/prio_arbiter_enc.sv | 23 ++
 rtl/prio_arbiter.sv | 110 +++++++++++
 tb/tb_prio_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/prio_arbiter_pkg.sv
// Shared encodings and helpers for the priority/round-robin arbiter.
package prio_arbiter_pkg;

  typedef enum logic {FIXED = 1'b0, RR = 1'b1} mode_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Index width, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_arbiter_enc.sv
// Highest-index-first priority encoder with a found flag.
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Ascending scan: the last set bit seen is the highest.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter: fixed priority or round-robin, with optional grant hold
// bounded by MAX_HOLD consecutive cycles while others are waiting.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDXW     = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            hold,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

  state_e            state, nxt_state;
  logic [IDXW-1:0]   ptr, nxt_ptr, nxt_idx, enc_idx, win;
  logic [N-1:0]      nxt_gnt, arb_req, rr_vec, enc_in;
  logic [7:0]        cnt, nxt_cnt;
  logic              enc_found, owner_req, others, lock, stay;

  always_comb begin
    owner_req = gnt_vld & hold & req[gnt_idx];
    others    = |(req & ~gnt);
    lock      = owner_req && (cnt < 8'(MAX_HOLD));
    // Hold budget spent but nobody else is asking: keep the grant as is.
    stay      = owner_req && !lock && !others;
    arb_req   = req;
    if (owner_req) arb_req[gnt_idx] = 1'b0;
    // Reverse the ptr-rotated vector so the lowest offset from ptr lands on
    // the highest bit, letting the same highest-first encoder serve RR.
    rr_vec = '0;
    for (int k = 0; k < N; k++)
      rr_vec[N-1-k] = arb_req[(int'(ptr) + k) % N];
    enc_in = (mode_e'(mode) == RR) ? rr_vec : arb_req;
  end

  prio_enc #(.N(N), .W(IDXW)) u_enc (
    .vec   (enc_in),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_comb begin
    if (mode_e'(mode) == RR)
      win = IDXW'((int'(ptr) + N - 1 - int'(enc_idx)) % N);
    else
      win = enc_idx;
  end

  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    nxt_idx   = gnt_idx;
    nxt_cnt   = cnt;
    nxt_ptr   = ptr;
    case (state)
      IDLE: begin
        if (enc_found) begin
          nxt_state = BUSY;
          nxt_gnt   = N'(1) << win;
          nxt_idx   = win;
          nxt_cnt   = 8'd1;
          nxt_ptr   = IDXW'((int'(win) + 1) % N);
        end
      end
      BUSY: begin
        if (lock) begin
          nxt_cnt = cnt + 8'd1;
        end else if (!stay) begin
          if (enc_found) begin
            nxt_gnt = N'(1) << win;
            nxt_idx = win;
            nxt_cnt = 8'd1;
            nxt_ptr = IDXW'((int'(win) + 1) % N);
          end else begin
            nxt_state = IDLE;
            nxt_gnt   = '0;
            nxt_idx   = '0;
            nxt_cnt   = 8'd0;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr     <= '0;
      cnt     <= 8'd0;
    end else begin
      state   <= nxt_state;
      gnt     <= nxt_gnt;
      gnt_idx <= nxt_idx;
      gnt_vld <= (nxt_state == BUSY);
      ptr     <= nxt_ptr;
      cnt     <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter (N=4, MAX_HOLD=3).
module tb_prio_arbiter;

  localparam int N  = 4;
  localparam int MH = 3;

  typedef struct {
    logic       vld;
    logic [1:0] idx;
    logic [3:0] gnt;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       mode = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;

  int nchk = 0;
  int nfail = 0;
  exp_t q[$];

  // reference model state
  logic       m_vld;
  int         m_idx, m_cnt, m_ptr;

  prio_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .hold(hold),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_vld = 1'b0; m_idx = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // Advance the model by one edge with the given inputs.
  task automatic m_step(input logic [3:0] r, input logic md, input logic hd);
    logic [3:0] cand;
    logic       own, oth;
    int         w;
    own = m_vld && hd && r[m_idx];
    oth = 1'b0;
    for (int i = 0; i < N; i++) if (r[i] && !(m_vld && i == m_idx)) oth = 1'b1;
    if (own && m_cnt < MH) begin
      m_cnt++;
    end else if (own && !oth) begin
      // saturated, alone: keep everything
    end else begin
      cand = r;
      if (own) cand[m_idx] = 1'b0;
      w = -1;
      if (!md) begin
        for (int i = N - 1; i >= 0; i--) if (w < 0 && cand[i]) w = i;
      end else begin
        for (int k = 0; k < N; k++) if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w < 0) begin
        m_vld = 1'b0; m_idx = 0; m_cnt = 0;
      end else begin
        m_vld = 1'b1; m_idx = w; m_cnt = 1; m_ptr = (w + 1) % N;
      end
    end
  endtask

  // Called just after a rising edge: drive, predict, clock, compare.
  task automatic cyc(input string tag, input logic [3:0] r, input logic md, input logic hd);
    exp_t e, o;
    req = r; mode = md; hold = hd;
    m_step(r, md, hd);
    e.vld = m_vld;
    e.idx = 2'(m_idx);
    e.gnt = m_vld ? 4'(1 << m_idx) : 4'h0;
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd0, 32'd1);
    end else begin
      o = q.pop_front();
      chk({o.tag, "_vld"}, 32'(gnt_vld), 32'(o.vld));
      chk({o.tag, "_idx"}, 32'(gnt_idx), 32'(o.idx));
      chk({o.tag, "_gnt"}, 32'(gnt), 32'(o.gnt));
    end
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    chk("rst_vld", 32'(gnt_vld), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cyc("idle", 4'b0000, 1'b0, 1'b0);
    cyc("fixed_1010", 4'b1010, 1'b0, 1'b0);
    chk("fixed_1010_abs", 32'(gnt_idx), 32'd3);

    for (int i = 0; i < 5; i++) begin
      cyc("rr_1111", 4'b1111, 1'b1, 1'b0);
      chk("rr_seq_abs", 32'(gnt_idx), 32'(i % N));
    end

    cyc("idle2", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc("hold_1001", 4'b1001, 1'b0, 1'b1);
      chk("hold_1001_abs", 32'(gnt_idx), (i < 3) ? 32'd3 : 32'd0);
    end
    for (int i = 0; i < 6; i++) cyc("hold_1000", 4'b1000, 1'b0, 1'b1);
    chk("hold_alone_abs", 32'(gnt_idx), 32'd3);

    cyc("drop_a", 4'b0100, 1'b0, 1'b1);
    cyc("drop_b", 4'b0101, 1'b0, 1'b1);
    cyc("drop_c", 4'b0001, 1'b0, 1'b1);
    chk("drop_abs", 32'(gnt_idx), 32'd0);

    for (int i = 0; i < 60; i++)
      cyc("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    cyc("pre_rst", 4'b1111, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_idx", 32'(gnt_idx), 32'd0);
    chk("mid_rst_vld", 32'(gnt_vld), 32'd0);
    m_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc("post_rst_rr", 4'b1111, 1'b1, 1'b0);
    chk("post_rst_abs", 32'(gnt_idx), 32'd0);
    cyc("post_rst_rr2", 4'b1111, 1'b1, 1'b0);
    cyc("final_idle", 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
